// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_drp_reconfig
// Brief    : Reprograms MMCME4 CLKOUTn integer dividers over DRP while the
//            MMCM is held in reset, then waits for LOCKED and reports status.
// Revision : 1.0 - initial release
// ============================================================================
module mmcm_drp_reconfig #(
    parameter int NUM_OUT      = 3,
    parameter int DIV_W        = 7,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                     clk_in0,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NUM_OUT*DIV_W-1:0] req_div,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mmcm_rst,
    input  logic                     locked,
    output logic [6:0]               daddr,
    output logic [15:0]              di,
    output logic                     den,
    output logic                     dwe,
    input  logic [15:0]              do_i,
    input  logic                     drdy,
    output logic                     clk_ce
);

    localparam int c_CNT_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DRP_LAST  = c_CNT_W'(DRP_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]         c_LAST_IDX  = 3'(NUM_OUT - 1);

    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_RST_ON    = 4'd1;
    localparam logic [3:0] c_S_RD1       = 4'd2;
    localparam logic [3:0] c_S_WR1       = 4'd3;
    localparam logic [3:0] c_S_RD2       = 4'd4;
    localparam logic [3:0] c_S_WR2       = 4'd5;
    localparam logic [3:0] c_S_RST_OFF   = 4'd6;
    localparam logic [3:0] c_S_WAIT_LOCK = 4'd7;
    localparam logic [3:0] c_S_DONE      = 4'd8;

    // ClkReg1 address per output; ClkReg2 always sits at the next odd address
    function automatic logic [6:0] reg1_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    reg1_addr = 7'h08;
            3'd1:    reg1_addr = 7'h0A;
            3'd2:    reg1_addr = 7'h0C;
            3'd3:    reg1_addr = 7'h0E;
            3'd4:    reg1_addr = 7'h10;
            3'd5:    reg1_addr = 7'h06;
            default: reg1_addr = 7'h12;
        endcase
    endfunction

    logic [3:0]               r_state;
    logic                     r_req_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     r_err_flag;
    logic                     r_mmcm_rst;
    logic                     r_den;
    logic                     r_dwe;
    logic [6:0]               r_daddr;
    logic [15:0]              r_di;
    logic                     r_clk_ce;
    logic [2:0]               r_idx;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [NUM_OUT*DIV_W-1:0] r_div;
    logic                     r_lock_s1;
    logic                     r_lock_s2;

    logic                     w_div_bad;
    logic [DIV_W-1:0]         w_cur_div;
    logic [DIV_W-1:0]         w_high;
    logic [DIV_W-1:0]         w_low;
    logic                     w_edge;
    logic                     w_nocnt;
    logic [6:0]               w_reg1_addr;
    logic [6:0]               w_reg2_addr;
    logic [15:0]              w_reg1_wr;
    logic [15:0]              w_reg2_wr;
    logic                     w_unused;

    always_comb begin
        w_div_bad = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if ((req_div[i*DIV_W +: DIV_W] == '0) ||
                (req_div[i*DIV_W +: DIV_W] > DIV_W'(126))) begin
                w_div_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_cur_div = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (r_idx == 3'(i)) begin
                w_cur_div = r_div[i*DIV_W +: DIV_W];
            end
        end
    end

    always_comb begin
        if (w_cur_div == DIV_W'(1)) begin
            w_high  = DIV_W'(1);
            w_low   = DIV_W'(1);
            w_edge  = 1'b0;
            w_nocnt = 1'b1;
        end else begin
            w_high  = w_cur_div >> 1;
            w_low   = w_cur_div - w_high;
            w_edge  = w_cur_div[0];
            w_nocnt = 1'b0;
        end
    end

    // Write data is built straight from the read response so the preserved
    // bits never need a separate holding register.
    assign w_reg1_addr = reg1_addr(r_idx);
    assign w_reg2_addr = {w_reg1_addr[6:1], 1'b1};
    assign w_reg1_wr   = {do_i[15:12], w_low[5:0], w_high[5:0]};
    assign w_reg2_wr   = {do_i[15:8], w_edge, w_nocnt, 6'b0};
    assign w_unused    = ^{do_i[7:0], w_high, w_low};

    always_ff @(posedge clk_in0) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_flag  <= 1'b0;
            r_mmcm_rst  <= 1'b0;
            r_den       <= 1'b0;
            r_dwe       <= 1'b0;
            r_daddr     <= '0;
            r_di        <= '0;
            r_clk_ce    <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_div       <= '0;
            r_lock_s1   <= 1'b0;
            r_lock_s2   <= 1'b0;
        end else begin
            r_lock_s1 <= locked;
            r_lock_s2 <= r_lock_s1;
            r_den     <= 1'b0;
            r_dwe     <= 1'b0;
            r_done    <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_clk_ce <= r_lock_s2;
                    if (req_valid && r_req_ready) begin
                        if (w_div_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_err       <= 1'b0;
                            r_err_flag  <= 1'b0;
                            r_div       <= req_div;
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_mmcm_rst  <= 1'b1;
                            r_clk_ce    <= 1'b0;
                            r_state     <= c_S_RST_ON;
                        end
                    end
                end

                c_S_RST_ON: begin
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    r_den   <= 1'b1;
                    r_daddr <= reg1_addr(3'd0);
                    r_state <= c_S_RD1;
                end

                c_S_RD1, c_S_WR1, c_S_RD2, c_S_WR2: begin
                    // A drdy in the den cycle belongs to nothing we issued
                    if (drdy && !r_den) begin
                        r_cnt <= '0;
                        case (r_state)
                            c_S_RD1: begin
                                r_den   <= 1'b1;
                                r_dwe   <= 1'b1;
                                r_di    <= w_reg1_wr;
                                r_state <= c_S_WR1;
                            end
                            c_S_WR1: begin
                                r_den   <= 1'b1;
                                r_daddr <= w_reg2_addr;
                                r_state <= c_S_RD2;
                            end
                            c_S_RD2: begin
                                r_den   <= 1'b1;
                                r_dwe   <= 1'b1;
                                r_di    <= w_reg2_wr;
                                r_state <= c_S_WR2;
                            end
                            default: begin
                                if (r_idx == c_LAST_IDX) begin
                                    r_mmcm_rst <= 1'b0;
                                    r_state    <= c_S_RST_OFF;
                                end else begin
                                    r_idx   <= r_idx + 3'd1;
                                    r_den   <= 1'b1;
                                    r_daddr <= reg1_addr(r_idx + 3'd1);
                                    r_state <= c_S_RD1;
                                end
                            end
                        endcase
                    end else if (r_cnt == c_DRP_LAST) begin
                        r_err_flag <= 1'b1;
                        r_mmcm_rst <= 1'b0;
                        r_state    <= c_S_RST_OFF;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                c_S_RST_OFF: begin
                    r_cnt   <= '0;
                    r_state <= c_S_WAIT_LOCK;
                end

                c_S_WAIT_LOCK: begin
                    if (r_lock_s2) begin
                        r_done  <= 1'b1;
                        r_err   <= r_err_flag;
                        r_state <= c_S_DONE;
                    end else if (r_cnt == c_LOCK_LAST) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                c_S_DONE: begin
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mmcm_rst  = r_mmcm_rst;
    assign daddr     = r_daddr;
    assign di        = r_di;
    assign den       = r_den;
    assign dwe       = r_dwe;
    assign clk_ce    = r_clk_ce;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmcm_drp_reconfig
// Brief    : Self-checking bench for mmcm_drp_reconfig with a DRP/MMCM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmcm_drp_reconfig;

    localparam int NUM_OUT  = 3;
    localparam int DIV_W    = 7;
    localparam int LOCK_DLY = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset     = 1'b1;
    logic                     req_valid = 1'b0;
    logic [NUM_OUT*DIV_W-1:0] req_div   = '0;
    logic                     locked    = 1'b1;
    logic [15:0]              do_i      = '0;
    logic                     drdy      = 1'b0;
    logic                     req_ready, busy, done, err, mmcm_rst, den, dwe, clk_ce;
    logic [6:0]               daddr;
    logic [15:0]              di;

    mmcm_drp_reconfig #(
        .NUM_OUT     (NUM_OUT),
        .DIV_W       (DIV_W),
        .DRP_TIMEOUT (64),
        .LOCK_TIMEOUT(65535)
    ) dut (
        .clk_in0  (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_div  (req_div),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mmcm_rst (mmcm_rst),
        .locked   (locked),
        .daddr    (daddr),
        .di       (di),
        .den      (den),
        .dwe      (dwe),
        .do_i     (do_i),
        .drdy     (drdy),
        .clk_ce   (clk_ce)
    );

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t exp_acc[$];
    logic exp_err[$];
    int   checks = 0;
    int   errors = 0;

    // Written by the test tasks, read by the model
    logic [15:0] rd1_val    = 16'h0000;
    logic [15:0] rd2_val    = 16'h0000;
    int          hold_at    = -1;
    int          abort_req  = 0;
    int          stray_req  = 0;
    bit          lock_never = 1'b0;
    bit          lock_drop  = 1'b0;

    // Owned by the model
    int          acc_num    = 0;
    int          abort_seen = 0;
    int          stray_seen = 0;
    bit          pend       = 1'b0;
    bit          p_hold     = 1'b0;
    logic [6:0]  p_addr     = '0;
    logic        p_we       = 1'b0;
    logic [15:0] p_di       = '0;
    int          lat_cnt    = 0;
    int          lcnt       = 0;

    always @(negedge clk) begin : drp_model
        acc_t a;
        logic e;
        drdy = 1'b0;
        if (abort_seen != abort_req) begin
            abort_seen = abort_req;
            pend       = 1'b0;
        end
        if (pend && !reset) begin
            checks++;
            if (daddr !== p_addr || (p_we && di !== p_di)) begin
                errors++;
                $display("FAIL drp_hold: daddr=%h di=%h required daddr=%h di=%h", daddr, di, p_addr, p_di);
            end
            if (!p_hold) begin
                if (lat_cnt == 0) begin
                    drdy = 1'b1;
                    do_i = p_addr[0] ? rd2_val : rd1_val;
                    pend = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
        end else if (stray_seen != stray_req) begin
            stray_seen = stray_req;
            drdy       = 1'b1;
        end
        if (!reset && den === 1'b1) begin
            checks++;
            acc_num++;
            if (pend) begin
                errors++;
                $display("FAIL drp_overlap: den=1 with access outstanding at %h, required no den", p_addr);
            end
            if (mmcm_rst !== 1'b1 || clk_ce !== 1'b0) begin
                errors++;
                $display("FAIL drp_rst_hold: mmcm_rst=%b clk_ce=%b required 1/0", mmcm_rst, clk_ce);
            end
            if (exp_acc.size() == 0) begin
                errors++;
                $display("FAIL drp_unexpected: we=%b addr=%h di=%h, required no access", dwe, daddr, di);
            end else begin
                a = exp_acc.pop_front();
                if (dwe !== a.we || daddr !== a.addr || (a.we && di !== a.data)) begin
                    errors++;
                    $display("FAIL drp_access: we=%b addr=%h di=%h required we=%b addr=%h di=%h",
                             dwe, daddr, di, a.we, a.addr, a.data);
                end
            end
            pend    = 1'b1;
            p_addr  = daddr;
            p_we    = dwe;
            p_di    = di;
            lat_cnt = $urandom_range(0, 2);
            p_hold  = (acc_num == hold_at);
        end
        if (mmcm_rst === 1'b1 || lock_drop) begin
            locked = 1'b0;
            lcnt   = 0;
        end else if (!locked && !lock_never) begin
            lcnt++;
            if (lcnt >= LOCK_DLY) locked = 1'b1;
        end
        if (!reset && done === 1'b1) begin
            checks++;
            if (exp_err.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done=1 err=%b, required no done", err);
            end else begin
                e = exp_err.pop_front();
                if (err !== e) begin
                    errors++;
                    $display("FAIL done_err: err=%b required %b", err, e);
                end
            end
        end
    end

    task automatic push_out(input logic [6:0] a1, input logic [15:0] w1, input logic [15:0] w2);
        exp_acc.push_back({1'b0, a1, 16'h0000});
        exp_acc.push_back({1'b1, a1, w1});
        exp_acc.push_back({1'b0, a1 + 7'd1, 16'h0000});
        exp_acc.push_back({1'b1, a1 + 7'd1, w2});
    endtask

    task automatic do_request(input logic [NUM_OUT*DIV_W-1:0] div);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_div   = div;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
        @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_acc.size() != 0 || exp_err.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d accesses and %0d dones left, required 0/0", name, exp_acc.size(), exp_err.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({den, dwe, mmcm_rst, done, err, busy, clk_ce, daddr, di} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: den=%b dwe=%b rst=%b done=%b err=%b busy=%b ce=%b daddr=%h di=%h required all 0",
                     den, dwe, mmcm_rst, done, err, busy, clk_ce, daddr, di);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (clk_ce !== 1'b1) begin
            errors++;
            $display("FAIL idle_clk_ce: clk_ce=%b required 1", clk_ce);
        end
    endtask

    task automatic test_three_outputs();
        rd1_val = 16'hF000;
        rd2_val = 16'h0000;
        stray_req++;
        repeat (3) @(negedge clk);
        push_out(7'h08, 16'hF082, 16'h0000);
        push_out(7'h0A, 16'hF0C3, 16'h0000);
        push_out(7'h0C, 16'hF103, 16'h0080);
        exp_err.push_back(1'b0);
        do_request({7'd7, 7'd6, 7'd4});
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || mmcm_rst !== 1'b1) begin
            errors++;
            $display("FAIL busy_state: busy=%b req_ready=%b mmcm_rst=%b required 1/0/1", busy, req_ready, mmcm_rst);
        end
        wait_done(500);
        check_drained("three_outputs_drain");
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy=%b req_ready=%b err=%b required 0/1/0", busy, req_ready, err);
        end
    endtask

    task automatic test_div_boundaries();
        rd1_val = 16'h0000;
        rd2_val = 16'h0000;
        push_out(7'h08, 16'h0041, 16'h0040);
        push_out(7'h0A, 16'h0041, 16'h0000);
        push_out(7'h0C, 16'h0FFF, 16'h0000);
        exp_err.push_back(1'b0);
        do_request({7'd126, 7'd2, 7'd1});
        wait_done(500);
        check_drained("div_boundaries_drain");
    endtask

    task automatic test_invalid();
        int base;
        logic [NUM_OUT*DIV_W-1:0] bad [2];
        bad[0] = {7'd4, 7'd0, 7'd4};
        bad[1] = {7'd127, 7'd4, 7'd4};
        base = acc_num;
        for (int k = 0; k < 2; k++) begin
            exp_err.push_back(1'b1);
            do_request(bad[k]);
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || mmcm_rst !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL invalid_%0d: done=%b err=%b rst=%b busy=%b ready=%b required 1/1/0/0/1",
                         k, done, err, mmcm_rst, busy, req_ready);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (acc_num != base) begin
            errors++;
            $display("FAIL invalid_no_den: %0d accesses issued, required 0", acc_num - base);
        end
        check_drained("invalid_drain");
    endtask

    task automatic test_idle_lock();
        lock_drop = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (clk_ce !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_unlock: clk_ce=%b busy=%b required 0/0", clk_ce, busy);
        end
        lock_drop = 1'b0;
        repeat (LOCK_DLY + 6) @(negedge clk);
        checks++;
        if (clk_ce !== 1'b1) begin
            errors++;
            $display("FAIL idle_relock: clk_ce=%b required 1", clk_ce);
        end
    endtask

    task automatic test_drdy_timeout();
        int n;
        rd1_val = 16'hF000;
        rd2_val = 16'h0000;
        hold_at = acc_num + 2;
        exp_acc.push_back({1'b0, 7'h08, 16'h0000});
        exp_acc.push_back({1'b1, 7'h08, 16'hF082});
        exp_err.push_back(1'b1);
        do_request({7'd4, 7'd4, 7'd4});
        n = 0;
        while (!(den === 1'b1 && dwe === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(den === 1'b1 && dwe === 1'b1)) begin
            errors++;
            $display("FAIL timeout_wr1: den=%b dwe=%b required 1/1", den, dwe);
        end
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 63 || n > 65) begin
            errors++;
            $display("FAIL drdy_timeout: mmcm_rst fell %0d cycles after den, required 64", n);
        end
        hold_at = -1;
        abort_req++;
        wait_done(300);
        check_drained("timeout_drain");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: err=%b required 1", err);
        end
    endtask

    task automatic test_lock_timeout();
        int n;
        rd1_val    = 16'hF000;
        rd2_val    = 16'h0000;
        lock_never = 1'b1;
        for (int k = 0; k < 3; k++) push_out(7'h08 + 7'(2 * k), 16'hF041, 16'h0000);
        exp_err.push_back(1'b1);
        do_request({7'd2, 7'd2, 7'd2});
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (done !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 65530 || n > 65545) begin
            errors++;
            $display("FAIL lock_timeout: done %0d cycles after mmcm_rst release, required about 65536", n);
        end
        @(negedge clk);
        lock_never = 1'b0;
        check_drained("lock_timeout_drain");
    endtask

    task automatic test_reset_mid_write();
        int n;
        rd1_val = 16'h5A5A;
        rd2_val = 16'hAB3F;
        hold_at = acc_num + 2;
        exp_acc.push_back({1'b0, 7'h08, 16'h0000});
        exp_acc.push_back({1'b1, 7'h08, 16'h50C2});
        do_request({7'd5, 7'd5, 7'd5});
        n = 0;
        while (!(den === 1'b1 && dwe === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (den !== 1'b0 || mmcm_rst !== 1'b0 || busy !== 1'b0 || clk_ce !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: den=%b rst=%b busy=%b ce=%b ready=%b required 0/0/0/0/1",
                     den, mmcm_rst, busy, clk_ce, req_ready);
        end
        hold_at = -1;
        abort_req++;
        reset = 1'b0;
        @(negedge clk);
        check_drained("mid_reset_drain");
        for (int k = 0; k < 3; k++) push_out(7'h08 + 7'(2 * k), 16'h50C2, 16'hAB80);
        exp_err.push_back(1'b0);
        do_request({7'd5, 7'd5, 7'd5});
        wait_done(500);
        check_drained("resubmit_drain");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL resubmit_err: err=%b required 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_three_outputs();
        test_div_boundaries();
        test_invalid();
        test_idle_lock();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
